// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package mdu_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MSUB  = 3'd7;

   localparam int unsigned DEF_MULT_CYCLES = 5;
   localparam int unsigned DEF_DIV_CYCLES  = 10;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational result generator for the MDU. Produces the HI/LO values that
// the latched operation would write; HI/LO pass through unchanged for
// division by zero and for ops that are not arithmetic.
// Optional MADD/MSUB support is enabled by defining MDU_MADD_EN.
module mdu_arith import mdu_pkg::*; #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [2*WIDTH-1:0] w_prod_s;
   logic [2*WIDTH-1:0] w_prod_u;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH-1:0]   w_quo_s;
   logic [WIDTH-1:0]   w_rem_s;
   logic [WIDTH-1:0]   w_quo_u;
   logic [WIDTH-1:0]   w_rem_u;
   logic               w_b_zero;

   // Products, and signed division done on magnitudes so that the
   // most-negative / -1 case wraps cleanly instead of overflowing.
   always_comb begin
      w_prod_s = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
      w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
      w_b_zero = (i_b == '0);
      w_mag_a  = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
      w_mag_b  = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;
      w_quo_u  = '0;
      w_rem_u  = '0;
      w_quo_s  = '0;
      w_rem_s  = '0;
      if (!w_b_zero) begin
         w_quo_u = i_a / i_b;
         w_rem_u = i_a % i_b;
         w_quo_s = w_mag_a / w_mag_b;
         w_rem_s = w_mag_a % w_mag_b;
         if (i_a[WIDTH-1] ^ i_b[WIDTH-1]) w_quo_s = ~w_quo_s + 1'b1;
         if (i_a[WIDTH-1])                w_rem_s = ~w_rem_s + 1'b1;
      end
   end

   // Select the result for the latched op; default keeps HI/LO.
   always_comb begin
      o_hi = i_hi;
      o_lo = i_lo;
      case (i_op)
         OP_MULT:  {o_hi, o_lo} = w_prod_s;
         OP_MULTU: {o_hi, o_lo} = w_prod_u;
         OP_DIV: begin
            if (!w_b_zero) begin
               o_hi = w_rem_s;
               o_lo = w_quo_s;
            end
         end
         OP_DIVU: begin
            if (!w_b_zero) begin
               o_hi = w_rem_u;
               o_lo = w_quo_u;
            end
         end
`ifdef MDU_MADD_EN
         OP_MADD:  {o_hi, o_lo} = {i_hi, i_lo} + w_prod_s;
         OP_MSUB:  {o_hi, o_lo} = {i_hi, i_lo} - w_prod_s;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// A start pulse launches a fixed-latency operation; busy is held for the
// configured number of cycles and the result lands on the final edge.
// Defining MDU_MADD_EN adds MADD (op 6) and MSUB (op 7).
module mdu_unit import mdu_pkg::*; #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   state_e           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;
   logic             w_latch;
   logic             w_is_mul;
   logic             w_is_div;
   logic [WIDTH-1:0] w_res_hi;
   logic [WIDTH-1:0] w_res_lo;

   mdu_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .i_a  (r_a),
      .i_b  (r_b),
      .i_op (r_op),
      .i_hi (r_hi),
      .i_lo (r_lo),
      .o_hi (w_res_hi),
      .o_lo (w_res_lo)
   );

   // Classify the incoming op into multi-cycle multiply or divide classes.
   always_comb begin
      w_is_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
`ifdef MDU_MADD_EN
      w_is_mul = w_is_mul || (i_op == OP_MADD) || (i_op == OP_MSUB);
`endif
      w_is_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
   end

   // Next-state, counter and HI/LO update logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      w_latch     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if (w_is_mul || w_is_div) begin
                  w_latch     = 1'b1;
                  w_cnt_nxt   = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  w_state_nxt = S_RUN;
               end else if (i_op == OP_MTHI) begin
                  w_hi_nxt = i_a;
               end else if (i_op == OP_MTLO) begin
                  w_lo_nxt = i_a;
               end
            end
         end
         S_RUN: begin
            // Start and MTHI/MTLO are ignored while running.
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_hi_nxt    = w_res_hi;
               w_lo_nxt    = w_res_lo;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
         if (w_latch) begin
            r_a  <= i_a;
            r_b  <= i_b;
            r_op <= i_op;
         end
      end
   end

   assign o_busy = (r_state == S_RUN);
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: table of directed vectors plus
// hand-written sequences for reset-in-flight and start-while-busy.
module tb_mdu_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors = 0;
   int checks = 0;

   mdu_unit #(
      .WIDTH       (32),
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .i_start (start),
      .i_op    (op),
      .i_a     (a),
      .i_b     (b),
      .o_busy  (busy),
      .o_hi    (hi),
      .o_lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          cyc;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mt(input logic [2:0] which, input logic [31:0] val);
      start = 1'b1;
      op    = which;
      a     = val;
      tick();
      start = 1'b0;
      check("mt_no_busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 50) begin
         n++;
         a = $urandom;
         b = $urandom;
         tick();
      end
   endtask

   initial begin
      int n;
      reset = 1'b0;
      start = 1'b0;
      op    = 3'd0;
      a     = '0;
      b     = '0;

      vecs.push_back('{"mult_neg3x7",   3'd0, 32'hFFFFFFFD, 32'd7,        32'h1, 32'h2,
                       32'hFFFFFFFF, 32'hFFFFFFEB, 5});
      vecs.push_back('{"divu_100_7",    3'd3, 32'd100,      32'd7,        32'h1, 32'h2,
                       32'd2,        32'd14,       10});
      vecs.push_back('{"div_neg7_2",    3'd2, 32'hFFFFFFF9, 32'd2,        32'h1, 32'h2,
                       32'hFFFFFFFF, 32'hFFFFFFFD, 10});
      vecs.push_back('{"div_by_zero",   3'd2, 32'd55,       32'd0,        32'h11, 32'h22,
                       32'h11,       32'h22,       10});
      vecs.push_back('{"multu_max",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                       32'hFFFFFFFE, 32'h00000001, 5});
      vecs.push_back('{"div_min_m1",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6,
                       32'h0,        32'h80000000, 10});
      vecs.push_back('{"div_7_neg2",    3'd2, 32'd7,        32'hFFFFFFFE, 32'h0, 32'h0,
                       32'd1,        32'hFFFFFFFD, 10});
      vecs.push_back('{"divu_big",      3'd3, 32'hFFFFFFFF, 32'h10,       32'h0, 32'h0,
                       32'hF,        32'h0FFFFFFF, 10});
      vecs.push_back('{"mult_min_sq",   3'd0, 32'h80000000, 32'h80000000, 32'h0, 32'h0,
                       32'h40000000, 32'h0,        5});
      vecs.push_back('{"div_neg8_3",    3'd2, 32'hFFFFFFF8, 32'd3,        32'h0, 32'h0,
                       32'hFFFFFFFE, 32'hFFFFFFFE, 10});
`ifdef MDU_MADD_EN
      vecs.push_back('{"madd_carry",    3'd6, 32'd1,        32'd1,        32'h0, 32'hFFFFFFFF,
                       32'h1,        32'h0,        5});
      vecs.push_back('{"msub_borrow",   3'd7, 32'd1,        32'd1,        32'h0, 32'h0,
                       32'hFFFFFFFF, 32'hFFFFFFFF, 5});
`else
      vecs.push_back('{"op6_reserved",  3'd6, 32'd1,        32'd1,        32'h0, 32'hFFFFFFFF,
                       32'h0,        32'hFFFFFFFF, 0});
      vecs.push_back('{"op7_reserved",  3'd7, 32'd1,        32'd1,        32'h3, 32'h4,
                       32'h3,        32'h4,        0});
`endif

      // Reset state
      tick();
      tick();
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      reset = 1'b1;
      tick();

      foreach (vecs[i]) begin
         mt(3'd4, vecs[i].pre_hi);
         mt(3'd5, vecs[i].pre_lo);
         check({vecs[i].name, "_pre_hi"}, hi, vecs[i].pre_hi);
         start = 1'b1;
         op    = vecs[i].op;
         a     = vecs[i].a;
         b     = vecs[i].b;
         tick();
         start = 1'b0;
         count_busy(n);
         check({vecs[i].name, "_cycles"}, n, vecs[i].cyc);
         check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
         check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      end

      // Reset asserted on cycle 3 of RUN discards the in-flight result.
      mt(3'd4, 32'h77);
      start = 1'b1;
      op    = 3'd1;
      a     = 32'hFFFFFFFF;
      b     = 32'd2;
      tick();
      start = 1'b0;
      check("rst_run_busy", {31'd0, busy}, 32'd1);
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_hi", hi, 32'd0);
      check("rst_mid_lo", lo, 32'd0);
      reset = 1'b1;
      repeat (12) tick();
      check("rst_late_hi", hi, 32'd0);
      check("rst_late_lo", lo, 32'd0);
      check("rst_late_busy", {31'd0, busy}, 32'd0);

      // MTLO and DIV start while busy are ignored; MULT lands on time.
      mt(3'd4, 32'hAA);
      mt(3'd5, 32'hBB);
      start = 1'b1;
      op    = 3'd0;
      a     = 32'd3;
      b     = 32'd4;
      tick();
      n = 0;
      while (busy && n < 50) begin
         n++;
         if (n == 1) begin
            start = 1'b1;
            op    = 3'd5;
            a     = 32'd5;
         end else if (n == 2) begin
            start = 1'b1;
            op    = 3'd2;
            a     = 32'd100;
            b     = 32'd7;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      check("busy_ign_cycles", n, 5);
      check("busy_ign_hi", hi, 32'd0);
      check("busy_ign_lo", lo, 32'd12);
      repeat (3) tick();
      check("busy_ign_no_div", {31'd0, busy}, 32'd0);
      check("busy_ign_lo_hold", lo, 32'd12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers. Sits in the E stage of the 5-stage MIPS pipeline, beside the ALU.
- Accepts one operation per start pulse and holds busy for a configurable latency. The hazard unit stalls D whenever busy|start is high and the D instruction uses the MDU.
- Exposes HI/LO for MFHI/MFLO and accepts MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be ≥1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (reset==0 at posedge clears the unit).
- start  in  1  one-cycle pulse launching a MULT/MULTU/DIV/DIVU.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (MADD/MSUB under option).
- a  in  WIDTH  rs operand, already forwarded.
- b  in  WIDTH  rt operand, already forwarded.
- busy  out  1  high while an operation is in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, state IDLE. Reset dominates every other input, including mid-operation; an in-flight result is discarded.
- States:
  - IDLE: start=1 with op∈{0..3} latches a, b and op into internal registers, loads the counter with MULT_CYCLES or DIV_CYCLES, and moves to RUN. busy rises on the next cycle.
  - RUN: counter decrements each cycle. When counter==1, the result is written to HI/LO at that edge, busy falls the same edge, and the state returns to IDLE.
  - Total visible busy = N cycles after the start edge. hi/lo show the new values in the first cycle busy==0.
- start while busy: ignored. The hazard unit prevents this case; the bench checks that state is unaffected.
- MTHI/MTLO (op 4/5):
  - Need no start. Written at the next edge when a write strobe is present, i.e. start=1 with op 4/5, in the same cycle.
  - Accepted only when busy==0; ignored when busy.
  - No busy assertion.
- Arithmetic:
  - MULT: signed WIDTH×WIDTH → 2·WIDTH; HI=upper, LO=lower.
  - MULTU: unsigned, same split.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned.
- Division by zero: operation runs full DIV_CYCLES; hi/lo unchanged.
- DIV of -2^(WIDTH-1) by -1: LO=-2^(WIDTH-1), HI=0. No trap.
- Reserved op with start=1: no effect, busy stays 0.
- Operands are captured at start. Changes on a/b during RUN have no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 6 = MADD and op 7 = MSUB, both signed, latency MULT_CYCLES.
  - Result: {hi,lo} ± a*b, computed with 2·WIDTH wrap-around.
  - The HI/LO value used is the one present at the final edge.
- Undefined: op 6/7 treated as reserved (no effect).

Decomposition:
- Shared package mdu_pkg holds:
  - op encoding localparams (OP_MULT..OP_MSUB).
  - state encoding (S_IDLE, S_RUN).
  - default latency constants.
- Sub-module mdu_arith: combinational result generator. Takes latched a, b, op and current hi/lo; produces next_hi/next_lo. The FSM/counter stays in the top.

Test Plan:
- MULT, a=-3 (0xFFFFFFFD), b=7, MULT_CYCLES=5 → busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU, a=100, b=7; then DIV, a=-7, b=2 → first gives lo=14, hi=2 after 10 busy cycles; second gives lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV with b=0, hi/lo preloaded via MTHI=0x11, MTLO=0x22 → busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- Start MULTU 0xFFFFFFFF×2, then assert reset=0 on cycle 3 of RUN → next cycle busy=0, hi=lo=0; no later write.
- MTLO 0x5 during busy, and start DIV during busy → both ignored; the original MULT result lands on time.
- With MDU_MADD_EN: MTHI 0, MTLO 0xFFFFFFFF, then MADD a=1, b=1 → hi=1, lo=0 after 5 cycles. Without the macro, same stimulus → hi/lo unchanged, busy stays 0.
